// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the fetch stage: instruction width, the NOP
// encoding and the JMP -1 (jump-to-self) pattern used for halt detection.
package cpu_pkg;

    localparam int unsigned INSTR_W = 32;

    typedef logic [INSTR_W-1:0] instr_t;

    localparam instr_t     NOP_INSTR  = 32'h0000_0000;
    localparam logic [5:0] OPCODE_JMP = 6'b101010;
    localparam instr_t     JMP_SELF   = {OPCODE_JMP, 26'h3FF_FFFF};

    typedef struct packed {
        instr_t      instr;
        logic [31:0] pc;
        logic        valid;
    } if_id_t;

    function automatic logic is_jmp_self(input instr_t instr);
        return instr == JMP_SELF;
    endfunction

endpackage

// File: rtl/pc_register.sv
// Program counter storage: synchronous active-high reset to RESET_VAL,
// load of d when en is high, hold otherwise.
module pc_register #(
    parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [31:0] d,
    output logic [31:0] q
);

    logic [31:0] pc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_VAL;
        end else if (en) begin
            pc_q <= d;
        end
    end

    assign q = pc_q;

endmodule

// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: PC sequencing with branch redirect and stall,
// plus the IF/ID pipeline register. Optional halt-on-JMP-self detection
// is enabled by defining IF_HALT_DETECT_EN.
module instruction_fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               freeze,
    input  logic               branch_taken,
    input  logic [31:0]        branch_addr,
    input  logic               flush,
    output logic [31:0]        imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [31:0]        pc_out,
    output logic [INSTR_W-1:0] instr_out,
    output logic               valid_out
`ifdef IF_HALT_DETECT_EN
    ,
    output logic               halted
`endif
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] pc_next_seq;
    logic        pc_en;
    logic        redirect;
    logic        stall_pc;
    logic        halted_now;
    if_id_t      if_id_q;
    if_id_t      if_id_d;

`ifdef IF_HALT_DETECT_EN
    logic halted_q;
    logic halted_d;
    logic halt_hit;

    // Only a JMP -1 that actually lands in IF/ID halts; the PC stays on it.
    assign halt_hit = !halted_q && !flush && !branch_taken && !freeze
                      && is_jmp_self(imem_data);
    assign halted_d = halted_q || halt_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= halted_d;
        end
    end

    assign halted_now = halted_q;
    assign stall_pc   = halted_q || halt_hit;
    assign halted     = halted_q;
`else
    assign halted_now = 1'b0;
    assign stall_pc   = 1'b0;
`endif

    assign redirect    = branch_taken && !halted_now;
    assign pc_next_seq = pc_q + PC_STEP;
    assign pc_en       = redirect || (!freeze && !stall_pc);
    assign pc_d        = redirect ? {branch_addr[31:2], 2'b00} : pc_next_seq;

    pc_register #(
        .RESET_VAL (RESET_PC)
    ) u_pc (
        .clk (clk),
        .rst (rst),
        .en  (pc_en),
        .d   (pc_d),
        .q   (pc_q)
    );

    always_comb begin
        if_id_d = if_id_q;
        if (flush || redirect) begin
            if_id_d = '{instr: NOP_INSTR, pc: 32'h0, valid: 1'b0};
        end else if (freeze) begin
            if_id_d = if_id_q;
        end else if (halted_now) begin
            if_id_d = '{instr: NOP_INSTR, pc: 32'h0, valid: 1'b0};
        end else begin
            if_id_d = '{instr: imem_data, pc: pc_next_seq, valid: 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            if_id_q <= '{instr: NOP_INSTR, pc: 32'h0, valid: 1'b0};
        end else begin
            if_id_q <= if_id_d;
        end
    end

    assign imem_addr = pc_q;
    assign instr_out = if_id_q.instr;
    assign pc_out    = if_id_q.pc;
    assign valid_out = if_id_q.valid;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Self-checking bench for instruction_fetch_stage: directed vector table,
// randomized run against a behavioural model, and halt sequences when
// IF_HALT_DETECT_EN is defined.
module tb_instruction_fetch_stage;

    localparam logic [31:0] JMP_WORD = 32'hABFF_FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        freeze = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_addr = 32'h0;
    logic        flush = 1'b0;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] pc_out;
    logic [31:0] instr_out;
    logic        valid_out;
`ifdef IF_HALT_DETECT_EN
    logic        halted;
`endif

    logic        jmp_en = 1'b0;
    logic [31:0] jmp_addr = 32'h0;

    int checks = 0;
    int failures = 0;

    // reference model state
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pcout;
    logic        m_valid;
    logic        m_halted;

    always #5 clk = ~clk;

    function automatic logic [31:0] imem_model(input logic [31:0] a);
        if (jmp_en && a == jmp_addr) return JMP_WORD;
        return 32'h1000_0000 + a;
    endfunction

    assign imem_data = imem_model(imem_addr);

    instruction_fetch_stage dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .flush        (flush),
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .pc_out       (pc_out),
        .instr_out    (instr_out),
        .valid_out    (valid_out)
`ifdef IF_HALT_DETECT_EN
        ,
        .halted       (halted)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behavioural next-state of the fetch stage from the written rules.
    task automatic model_edge(input logic r, fr, br, input logic [31:0] ba, input logic fl);
        logic        halt_feature;
        logic        take_br;
        logic        hit;
        logic [31:0] word;
`ifdef IF_HALT_DETECT_EN
        halt_feature = 1'b1;
`else
        halt_feature = 1'b0;
`endif
        if (r) begin
            m_pc = 32'h0; m_instr = 32'h0; m_pcout = 32'h0; m_valid = 1'b0; m_halted = 1'b0;
            return;
        end
        take_br = br && !m_halted;
        word    = imem_model(m_pc);
        hit     = halt_feature && !m_halted && !take_br && !fl && !fr && word == JMP_WORD;
        if (fl || take_br) begin
            m_instr = 32'h0; m_pcout = 32'h0; m_valid = 1'b0;
        end else if (fr) begin
            // hold
        end else if (m_halted) begin
            m_instr = 32'h0; m_pcout = 32'h0; m_valid = 1'b0;
        end else begin
            m_instr = word; m_pcout = m_pc + 32'd4; m_valid = 1'b1;
        end
        if (take_br) m_pc = ba & 32'hFFFF_FFFC;
        else if (!(fr || m_halted || hit)) m_pc = m_pc + 32'd4;
        m_halted = m_halted || hit;
    endtask

    task automatic step_model(input string tag, input logic r, fr, br,
                              input logic [31:0] ba, input logic fl);
        rst = r; freeze = fr; branch_taken = br; branch_addr = ba; flush = fl;
        model_edge(r, fr, br, ba, fl);
        @(posedge clk); #1;
        check({tag, ".imem_addr"}, imem_addr, m_pc);
        check({tag, ".instr_out"}, instr_out, m_instr);
        check({tag, ".pc_out"}, pc_out, m_pcout);
        check({tag, ".valid_out"}, {31'h0, valid_out}, {31'h0, m_valid});
`ifdef IF_HALT_DETECT_EN
        check({tag, ".halted"}, {31'h0, halted}, {31'h0, m_halted});
`endif
    endtask

    typedef struct {
        logic        r, fr, br, fl;
        logic [31:0] ba;
        logic [31:0] e_addr, e_instr, e_pc;
        logic        e_valid;
    } vec_t;

    vec_t vt[$];

    initial begin
        vt.push_back('{1,0,0,0,32'h0,         32'h0,        32'h0,        32'h0,  0}); // reset
        vt.push_back('{0,0,0,0,32'h0,         32'h4,        32'h1000_0000,32'h4,  1});
        vt.push_back('{0,0,0,0,32'h0,         32'h8,        32'h1000_0004,32'h8,  1});
        vt.push_back('{0,1,0,0,32'h0,         32'h8,        32'h1000_0004,32'h8,  1}); // freeze x3
        vt.push_back('{0,1,0,0,32'h0,         32'h8,        32'h1000_0004,32'h8,  1});
        vt.push_back('{0,1,0,0,32'h0,         32'h8,        32'h1000_0004,32'h8,  1});
        vt.push_back('{0,0,0,0,32'h0,         32'hC,        32'h1000_0008,32'hC,  1});
        vt.push_back('{0,0,0,0,32'h0,         32'h10,       32'h1000_000C,32'h10, 1});
        vt.push_back('{0,0,1,0,32'h41,        32'h40,       32'h0,        32'h0,  0}); // branch at 16
        vt.push_back('{0,0,0,0,32'h0,         32'h44,       32'h1000_0040,32'h44, 1});
        vt.push_back('{0,1,1,0,32'h14,        32'h14,       32'h0,        32'h0,  0}); // branch+freeze
        vt.push_back('{0,0,0,1,32'h0,         32'h18,       32'h0,        32'h0,  0}); // flush at 20
        vt.push_back('{0,0,0,0,32'h0,         32'h1C,       32'h1000_0018,32'h1C, 1});
        vt.push_back('{0,0,1,0,32'hFFFF_FFFE, 32'hFFFF_FFFC,32'h0,        32'h0,  0});
        vt.push_back('{0,0,0,0,32'h0,         32'h0,        32'h0FFF_FFFC,32'h0,  1}); // wrap
        vt.push_back('{0,1,0,1,32'h0,         32'h0,        32'h0,        32'h0,  0}); // flush+freeze
        vt.push_back('{0,0,0,0,32'h0,         32'h4,        32'h1000_0000,32'h4,  1});
        vt.push_back('{1,1,0,0,32'h0,         32'h0,        32'h0,        32'h0,  0}); // rst mid-freeze
        vt.push_back('{0,0,0,0,32'h0,         32'h4,        32'h1000_0000,32'h4,  1});

        #2;
        for (int i = 0; i < vt.size(); i++) begin
            rst = vt[i].r; freeze = vt[i].fr; branch_taken = vt[i].br;
            branch_addr = vt[i].ba; flush = vt[i].fl;
            @(posedge clk); #1;
            check($sformatf("vec%0d.imem_addr", i), imem_addr, vt[i].e_addr);
            check($sformatf("vec%0d.instr_out", i), instr_out, vt[i].e_instr);
            check($sformatf("vec%0d.pc_out", i), pc_out, vt[i].e_pc);
            check($sformatf("vec%0d.valid_out", i), {31'h0, valid_out}, {31'h0, vt[i].e_valid});
`ifdef IF_HALT_DETECT_EN
            check($sformatf("vec%0d.halted", i), {31'h0, halted}, 32'h0);
`endif
        end

`ifdef IF_HALT_DETECT_EN
        // JMP -1 at PC=12: halt, PC sticks, valid drops, branch ignored, rst clears
        jmp_en = 1'b1; jmp_addr = 32'hC;
        step_model("halt.rst", 1, 0, 0, 32'h0, 0);
        for (int i = 0; i < 3; i++) step_model("halt.run", 0, 0, 0, 32'h0, 0);
        step_model("halt.hit", 0, 0, 0, 32'h0, 0);
        check("halt.set", {31'h0, halted}, 32'h1);
        check("halt.addr_stuck", imem_addr, 32'hC);
        check("halt.jmp_loaded", instr_out, JMP_WORD);
        step_model("halt.nop", 0, 0, 0, 32'h0, 0);
        check("halt.valid_drop", {31'h0, valid_out}, 32'h0);
        step_model("halt.br_ignored", 0, 0, 1, 32'h100, 0);
        check("halt.br_addr", imem_addr, 32'hC);
        step_model("halt.clear", 1, 0, 0, 32'h0, 0);
        check("halt.cleared", {31'h0, halted}, 32'h0);
        // JMP -1 fetched together with flush must not halt
        for (int i = 0; i < 3; i++) step_model("nohalt.run", 0, 0, 0, 32'h0, 0);
        step_model("nohalt.flush", 0, 0, 0, 32'h0, 1);
        check("nohalt.flag", {31'h0, halted}, 32'h0);
        check("nohalt.pc_moves", imem_addr, 32'h10);
`endif

        // randomized run against the model, JMP -1 planted at 0x10
        jmp_en = 1'b1; jmp_addr = 32'h10;
        step_model("rnd.rst", 1, 0, 0, 32'h0, 0);
        for (int i = 0; i < 400; i++) begin
            logic        r, fr, br, fl;
            logic [31:0] ba;
            r  = ($urandom_range(0, 39) == 0);
            fr = ($urandom_range(0, 3) == 0);
            br = ($urandom_range(0, 5) == 0);
            fl = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 9) == 0) ba = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            else ba = 32'($urandom_range(0, 63));
            step_model($sformatf("rnd%0d", i), r, fr, br, ba, fl);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_stage.md
INSTRUCTION_FETCH_STAGE -- requirements
Module: instruction_fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have parameter PC_STEP, default 4, byte increment per sequential fetch.
REQ-003 SHALL have port clk, input, 1 bit, single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit, reset that is synchronous and active-high.
REQ-005 SHALL have port freeze, input, 1 bit, hazard stall: hold the PC and the IF/ID register.
REQ-006 SHALL have port branch_taken, input, 1 bit, redirect request.
REQ-007 SHALL have port branch_addr, input, 32 bits, redirect byte address.
REQ-008 SHALL have port flush, input, 1 bit, kill the IF/ID contents.
REQ-009 SHALL have port imem_addr, output, 32 bits, byte address to instruction memory; always equals PC.
REQ-010 SHALL have port imem_data, input, 32 bits, combinational read data from instruction memory.
REQ-011 SHALL have port pc_out, output, 32 bits, registered PC+PC_STEP of the fetched instruction.
REQ-012 SHALL have port instr_out, output, 32 bits, registered instruction to decode.
REQ-013 SHALL have port valid_out, output, 1 bit, instr_out holds a real fetched instruction.
REQ-014 SHALL have port halted, output, 1 bit, present only with IF_HALT_DETECT_EN.

Function
REQ-015 SHALL update the PC with this priority: rst -> RESET_PC; else branch_taken -> {branch_addr[31:2],2'b00}; else freeze -> hold; else PC+PC_STEP.
REQ-016 SHALL let branch_taken override freeze in the same cycle.
REQ-017 SHALL wrap the PC modulo 2^32, so that 32'hFFFF_FFFC+4 gives 32'h0.
REQ-018 SHALL update the IF/ID register with this priority: rst, flush or branch_taken -> instr_out=32'h0 (NOP), pc_out=0, valid_out=0; else freeze -> hold; else load imem_data, PC+PC_STEP and valid_out=1.
REQ-019 SHALL present the instruction at address A on instr_out exactly one cycle after PC=A, with no freeze in between.
REQ-020 SHALL hold an instruction under freeze for any number of cycles with no loss or duplication once freeze releases.
REQ-021 SHALL flush an instruction fetched in the cycle in which branch_taken is asserted; the redirect target appears on instr_out two edges after branch_taken.
REQ-022 SHALL treat flush together with freeze as flush.

Reset
REQ-023 SHALL, one edge after rst=1, hold PC=RESET_PC, instr_out=0, pc_out=0, valid_out=0 and halted=0.
REQ-024 SHALL let rst asserted mid-freeze, mid-branch or while halted override everything; fetch resumes from RESET_PC on the first edge with rst=0.

Configuration
REQ-025 SHALL, when IF_HALT_DETECT_EN is defined, set halted sticky when a loaded imem_data equals opcode 6'b101010 with offset field all ones (JMP -1).
REQ-026 SHALL, once halted=1, freeze the PC and then, after the JMP passes, load NOP with valid_out=0 into IF/ID.
REQ-027 SHALL ignore branch_taken while halted=1, and SHALL clear halted only on rst.
REQ-028 SHALL NOT set halted when the JMP -1 is fetched in a cycle with branch_taken or flush.
REQ-029 SHALL, when IF_HALT_DETECT_EN is not defined, have no halted port and no halt logic.

Structure
REQ-030 SHALL take NOP_INSTR, OPCODE_JMP, the JMP_SELF pattern and the instruction width from the shared package cpu_pkg.
REQ-031 SHALL implement the PC as sub-module pc_register (clk, rst, en, d, q).
REQ-032 SHALL keep the IF/ID register inline.

Verification
REQ-033 Reset then free-run with imem returning 32'h1000_0000+addr -> imem_addr 0,4,8,...; cycle 3 after reset release: instr_out=32'h1000_0008, pc_out=12, valid_out=1.
REQ-034 freeze high 3 cycles at PC=8 -> imem_addr stays 8; instr_out holds the addr-4 word; release gives 8,12 with no gaps.
REQ-035 branch_taken with branch_addr=32'h0000_0041 at PC=16 -> next PC=32'h40; next instr_out=0 with valid_out=0; then the word at 0x40.
REQ-036 branch_taken and freeze together -> redirect taken; flush alone at PC=20 -> valid_out=0 one cycle, PC continues at 24.
REQ-037 PC forced to 32'hFFFF_FFFC via branch -> following imem_addr=0.
REQ-038 With IF_HALT_DETECT_EN, imem returns 32'hABFF_FFFF at PC=12 -> halted=1, imem_addr stuck at 12, valid_out drops after one cycle; a branch is ignored; rst clears halted.
